aes_pair_queue: RTL and testbench

Parametrised input buffer for the AES datapath: it assembles a 128-bit word stream into {key, plaintext} pairs and holds up to DEPTH pairs in a FIFO with valid/ready handshakes on both sides. It sits between the host/UART word source and the AES round core, replacing single-pair capture with back-pressured, multi-pair buffering. An optional all-zero sync word realigns key/data framing.

---
 rtl/aes_queue_pkg.sv | 17 +
 rtl/aes_pair_fifo.sv | 79 +++++++
 rtl/aes_pair_queue.sv | 93 +++++++++
 tb/tb_aes_pair_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_queue_pkg.sv
// Shared types for the AES pair queue: word width, assembler states
// and the {key, data} pair carried through the FIFO.
package aes_queue_pkg;

   localparam int AES_WORD_W = 128;

   typedef enum logic {
      WAIT_KEY  = 1'b0,
      WAIT_DATA = 1'b1
   } aes_state_e;

   typedef struct packed {
      logic [AES_WORD_W-1:0] key;
      logic [AES_WORD_W-1:0] data;
   } aes_pair_t;

endpackage

// File: rtl/aes_pair_fifo.sv
// Synchronous FIFO of {key, data} pairs with registered count/empty/full.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module aes_pair_fifo
   import aes_queue_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  aes_pair_t     wr_pair,
   input  logic          pop,
   output aes_pair_t     rd_pair,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   aes_pair_t     mem_q [DEPTH];
   aes_pair_t     mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      do_push = push && !full_q;
      do_pop  = pop && !empty_q;
      if (do_push) begin
         mem_d[wr_q] = wr_pair;
         wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         empty_q <= empty_d;
         full_q  <= full_d;
      end
   end

   assign rd_pair = empty_q ? '0 : mem_q[rd_q];
   assign empty   = empty_q;
   assign full    = full_q;
   assign count   = count_q;

endmodule

// File: rtl/aes_pair_queue.sv
// Assembles a word stream into {key, plaintext} pairs and buffers them.
// Define AES_QUEUE_ZERO_SYNC_EN to treat an all-zero word as a framing sync.
module aes_pair_queue
   import aes_queue_pkg::*;
#(
   parameter int WORD_W = AES_WORD_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [WORD_W-1:0]        in_word,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WORD_W-1:0]        out_key,
   output logic [WORD_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   aes_state_e        state_q, state_d;
   logic [WORD_W-1:0] key_q, key_d;
   logic              accept;
   logic              is_sync;
   logic              push;
   aes_pair_t         wr_pair;
   aes_pair_t         head;

`ifdef AES_QUEUE_ZERO_SYNC_EN
   assign is_sync = (in_word == '0);
`else
   assign is_sync = 1'b0;
`endif

   // Ready comes from registered state only, so it never loops back on in_valid.
   assign in_ready = (state_q == WAIT_KEY) || !full;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      push    = 1'b0;
      unique case (state_q)
         WAIT_KEY: begin
            if (accept && !is_sync) begin
               key_d   = in_word;
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (accept) begin
               push    = !is_sync;
               state_d = WAIT_KEY;
            end
         end
         default: state_d = WAIT_KEY;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= WAIT_KEY;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
      end
   end

   assign wr_pair.key  = key_q;
   assign wr_pair.data = in_word;

   aes_pair_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .wr_pair (wr_pair),
      .pop     (out_ready),
      .rd_pair (head),
      .empty   (empty),
      .full    (full),
      .count   (count)
   );

   assign out_key   = head.key;
   assign out_data  = head.data;
   assign out_valid = !empty;

endmodule

// File: tb/tb_aes_pair_queue.sv
// Self-checking bench for aes_pair_queue: directed scenarios plus random
// traffic, all compared against a queue-based pair model.
module tb_aes_pair_queue;

   localparam int W     = 128;
   localparam int DEPTH = 4;
`ifdef AES_QUEUE_ZERO_SYNC_EN
   localparam bit SYNC = 1'b1;
`else
   localparam bit SYNC = 1'b0;
`endif

   logic                   clock = 1'b0;
   logic                   reset;
   logic [W-1:0]           in_word;
   logic                   in_valid;
   logic                   in_ready;
   logic [W-1:0]           out_key;
   logic [W-1:0]           out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic                   empty;
   logic                   full;
   logic [$clog2(DEPTH):0] count;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] kq[$];
   logic [W-1:0] dq[$];
   bit           have_key;
   logic [W-1:0] held_key;

   always #5 clock = ~clock;

   aes_pair_queue #(.WORD_W(W), .DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_word   (in_word),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_key   (out_key),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .empty     (empty),
      .full      (full),
      .count     (count)
   );

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit exp_ready();
      return !have_key || (kq.size() < DEPTH);
   endfunction

   task automatic check_outputs(input string tag);
      int n;
      n = kq.size();
      check({tag, ".count"}, W'(count), W'(n));
      check({tag, ".empty"}, W'(empty), W'(n == 0));
      check({tag, ".full"}, W'(full), W'(n == DEPTH));
      check({tag, ".out_valid"}, W'(out_valid), W'(n != 0));
      check({tag, ".out_key"}, out_key, n != 0 ? kq[0] : '0);
      check({tag, ".out_data"}, out_data, n != 0 ? dq[0] : '0);
      check({tag, ".in_ready"}, W'(in_ready), W'(exp_ready()));
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic cycle(input string tag, input logic v,
                        input logic [W-1:0] w, input logic r);
      bit acc;
      bit pop;
      check_outputs(tag);
      in_valid  = v;
      in_word   = w;
      out_ready = r;
      acc = v && exp_ready();
      pop = r && (kq.size() != 0);
      @(posedge clock);
      if (pop) begin
         void'(kq.pop_front());
         void'(dq.pop_front());
      end
      if (acc) begin
         if (SYNC && w == '0) begin
            have_key = 1'b0;
         end else if (!have_key) begin
            held_key = w;
            have_key = 1'b1;
         end else begin
            kq.push_back(held_key);
            dq.push_back(w);
            have_key = 1'b0;
         end
      end
      @(negedge clock);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_word   = '0;
      out_ready = 1'b0;
      reset     = 1'b1;
      @(negedge clock);
      reset     = 1'b0;
      kq.delete();
      dq.delete();
      have_key = 1'b0;
      held_key = '0;
   endtask

   function automatic logic [W-1:0] rand_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic drain(input string tag);
      for (int i = 0; i < 2 * DEPTH + 2; i++) begin
         cycle(tag, 1'b0, '0, 1'b1);
      end
   endtask

   initial begin
      logic [W-1:0] k;
      logic [W-1:0] d;
      reset = 1'b0;
      @(negedge clock);
      do_reset();
      check_outputs("reset");

      k = 128'h000102030405060708090a0b0c0d0e0f;
      d = 128'h00112233445566778899aabbccddeeff;
      cycle("basic_k", 1'b1, k, 1'b0);
      cycle("basic_d", 1'b1, d, 1'b0);
      check_outputs("basic_pair");
      check("basic_byte0", W'(out_key[7:0]), W'(8'h0f));
      check("basic_key", out_key, k);
      check("basic_data", out_data, d);
      drain("basic_drain");

      for (int i = 0; i < DEPTH; i++) begin
         cycle("fill_k", 1'b1, rand_word(), 1'b0);
         cycle("fill_d", 1'b1, rand_word(), 1'b0);
      end
      check("fill_full", W'(full), W'(1));
      cycle("fill_k5", 1'b1, 128'h55, 1'b0);
      check("fill_rdy_d5", W'(in_ready), W'(0));
      cycle("fill_d5_hold", 1'b1, 128'h5d, 1'b0);
      cycle("fill_pop", 1'b1, 128'h5d, 1'b1);
      cycle("fill_d5_in", 1'b1, 128'h5d, 1'b0);
      check("fill_refull", W'(full), W'(1));
      drain("fill_drain");

      cycle("pp_k", 1'b1, rand_word(), 1'b0);
      cycle("pp_d", 1'b1, rand_word(), 1'b0);
      cycle("pp_k", 1'b1, rand_word(), 1'b0);
      cycle("pp_d", 1'b1, rand_word(), 1'b0);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         cycle("pp_k", 1'b1, rand_word(), 1'b0);
         cycle("pp_d", 1'b1, rand_word(), 1'b1);
      end
      check("pp_count", W'(count), W'(2));
      drain("pp_drain");

      cycle("sync_k1", 1'b1, 128'hA1, 1'b0);
      cycle("sync_z", 1'b1, '0, 1'b0);
      cycle("sync_k2", 1'b1, 128'hB2, 1'b0);
      cycle("sync_d2", 1'b1, 128'hD2, 1'b0);
      check("sync_key", out_key, SYNC ? 128'hB2 : 128'hA1);
      check("sync_data", out_data, SYNC ? 128'hD2 : '0);
      drain("sync_drain");
      do_reset();

      for (int i = 0; i < 2; i++) begin
         cycle("mid_k", 1'b1, rand_word(), 1'b0);
         cycle("mid_d", 1'b1, rand_word(), 1'b0);
      end
      cycle("mid_pk", 1'b1, 128'hEE, 1'b0);
      do_reset();
      check_outputs("mid_reset");
      cycle("mid_k", 1'b1, 128'hC1, 1'b0);
      cycle("mid_d", 1'b1, 128'hC2, 1'b0);
      check("mid_key", out_key, 128'hC1);
      check("mid_cnt", W'(count), W'(1));
      drain("mid_drain");

      for (int i = 0; i < 3; i++) begin
         cycle("empty_pop", 1'b0, '0, 1'b1);
      end
      cycle("ep_k", 1'b1, 128'h71, 1'b0);
      cycle("ep_d", 1'b1, 128'h72, 1'b0);
      check("ep_key", out_key, 128'h71);
      drain("ep_drain");

      for (int i = 0; i < 2000; i++) begin
         logic [W-1:0] w;
         w = ($urandom_range(0, 7) == 0) ? '0 : rand_word();
         cycle("rand", ($urandom_range(0, 9) < 7), w,
               ($urandom_range(0, 1) == 1));
      end
      check_outputs("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
